priority_arbiter_n: RTL and testbench

Parametrised, registered priority encoder/arbiter: N request lines in, a binary grant index plus one-hot grant out, held until the requester releases it. Successor to the 4-input combinational priority encoder. Adds width generalisation, a lock/release handshake and an optional round-robin priority mode. It sits between multiple requesters and a single shared resource, such as a bus or a memory port.

---
 rtl/priority_arbiter_n.sv | 109 ++++++++++
 tb/tb_priority_arbiter_n.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n: registered N-input priority arbiter with lock/release.
// A grant is held in BUSY until the owner pulses done or e drops.
// Optional round-robin priority when PRIORITY_ARBITER_N_ROUND_ROBIN_EN is
// defined; otherwise the highest set request index wins.
module priority_arbiter_n #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] x,
  input  logic         done,
  output logic [W-1:0] y,
  output logic [N-1:0] gnt,
  output logic         v
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state;
  logic [W-1:0]   win;
  logic [N-1:0]   win_onehot;
  logic           any_req;

`ifdef PRIORITY_ARBITER_N_ROUND_ROBIN_EN
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_next;

  // Round-robin pick: first set request at or after ptr, wrapping at N-1.
  always_comb begin
    logic hit;
    win = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!hit && x[W'(idx)]) begin
        win = W'(idx);
        hit = 1'b1;
      end
    end
  end

  // Pointer advances past the winner, wrapping N-1 back to 0.
  always_comb begin
    ptr_next = (win == W'(N - 1)) ? '0 : win + W'(1);
  end
`else
  // Fixed pick: ascending scan so the highest set index is the last written.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (x[W'(i)]) win = W'(i);
    end
  end
`endif

  // One-hot form of the winner and the request-present flag.
  always_comb begin
    any_req    = |x;
    win_onehot = {{(N-1){1'b0}}, 1'b1} << win;
  end

  // Grant FSM: IDLE issues a grant, BUSY freezes it until done or e=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      gnt   <= '0;
      v     <= 1'b0;
`ifdef PRIORITY_ARBITER_N_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (e && any_req) begin
            state <= BUSY;
            y     <= win;
            gnt   <= win_onehot;
            v     <= 1'b1;
`ifdef PRIORITY_ARBITER_N_ROUND_ROBIN_EN
            ptr   <= ptr_next;
`endif
          end else begin
            gnt <= '0;
            v   <= 1'b0;
          end
        end
        BUSY: begin
          // e=0 and done both release; y keeps the last owner.
          if (!e || done) begin
            state <= IDLE;
            gnt   <= '0;
            v     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          v     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// tb_priority_arbiter_n: directed bench for priority_arbiter_n at N=4, 2, 8.
// Expectations follow PRIORITY_ARBITER_N_ROUND_ROBIN_EN when it is defined.
module tb_priority_arbiter_n;

`ifdef PRIORITY_ARBITER_N_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       e;

  logic [3:0] x4;
  logic       done4;
  logic [1:0] y4;
  logic [3:0] gnt4;
  logic       v4;

  logic [1:0] x2;
  logic       done2;
  logic [0:0] y2;
  logic [1:0] gnt2;
  logic       v2;

  logic [7:0] x8;
  logic       done8;
  logic [2:0] y8;
  logic [7:0] gnt8;
  logic       v8;

  int checks;
  int failures;

  priority_arbiter_n #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .e(e), .x(x4), .done(done4),
    .y(y4), .gnt(gnt4), .v(v4)
  );

  priority_arbiter_n #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .e(e), .x(x2), .done(done2),
    .y(y2), .gnt(gnt2), .v(v2)
  );

  priority_arbiter_n #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .e(e), .x(x8), .done(done8),
    .y(y8), .gnt(gnt8), .v(v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input int ey, input logic [3:0] eg, input logic ev);
    check({tag, "_y"}, 32'(y4), 32'(ey));
    check({tag, "_gnt"}, 32'(gnt4), 32'(eg));
    check({tag, "_v"}, 32'(v4), 32'(ev));
  endtask

  // Grant from IDLE, then release with done; leaves the DUT in IDLE.
  task automatic grant_cycle4(input string tag, input logic [3:0] xv, input int ey);
    logic [3:0] eg;
    eg    = 4'b0001 << ey;
    x4    = xv;
    done4 = 1'b0;
    tick();
    check4({tag, "_grant"}, ey, eg, 1'b1);
    done4 = 1'b1;
    tick();
    check4({tag, "_rel"}, ey, 4'b0000, 1'b0);
    done4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    e     = 1'b1;
    x4 = '0; x2 = '0; x8 = '0;
    done4 = 1'b0; done2 = 1'b0; done8 = 1'b0;

    // Reset held
    #12;
    check4("rst_hold", 0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with no requests for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check4("idle", 0, 4'b0000, 1'b0);
    end

    // First grant with x=0101
    x4 = 4'b0101;
    tick();
    check4("first", RR ? 0 : 2, RR ? 4'b0001 : 4'b0100, 1'b1);

    // Frozen while BUSY across request changes, including the granted bit dropping
    x4 = 4'b1111;
    tick();
    check4("frz_all", RR ? 0 : 2, RR ? 4'b0001 : 4'b0100, 1'b1);
    x4 = 4'b0000;
    tick();
    check4("frz_none", RR ? 0 : 2, RR ? 4'b0001 : 4'b0100, 1'b1);

    // Release with done; y keeps its value
    x4    = 4'b1111;
    done4 = 1'b1;
    tick();
    check4("release", RR ? 0 : 2, 4'b0000, 1'b0);
    done4 = 1'b0;

    // Next grant from 1111
    tick();
    check4("regrant", RR ? 1 : 3, RR ? 4'b0010 : 4'b1000, 1'b1);
    done4 = 1'b1;
    tick();
    check("regrant_rel_v", 32'(v4), 32'(0));
    done4 = 1'b0;

    // Enable abort during BUSY with y=1
    x4 = 4'b0010;
    tick();
    check4("pre_abort", 1, 4'b0010, 1'b1);
    e = 1'b0;
    tick();
    check4("e_abort", 1, 4'b0000, 1'b0);
    tick();
    check4("e_low_idle", 1, 4'b0000, 1'b0);
    e = 1'b1;
    tick();
    check4("e_back", 1, 4'b0010, 1'b1);

    // Asynchronous reset mid-BUSY, checked before any clock edge
    rst_n = 1'b0;
    #2;
    check4("async_rst", 0, 4'b0000, 1'b0);
    tick();
    rst_n = 1'b1;

    // done in IDLE with no request is ignored
    x4    = 4'b0000;
    done4 = 1'b1;
    tick();
    check4("done_idle", 0, 4'b0000, 1'b0);
    done4 = 1'b0;

    // All requesting, done each grant: RR walks 0,1,2,3,0 including the wrap
    grant_cycle4("all0", 4'b1111, RR ? 0 : 3);
    grant_cycle4("all1", 4'b1111, RR ? 1 : 3);
    grant_cycle4("all2", 4'b1111, RR ? 2 : 3);
    grant_cycle4("all3", 4'b1111, RR ? 3 : 3);
    grant_cycle4("all4", 4'b1111, RR ? 0 : 3);

    // Sparse requests after a grant of 3
    grant_cycle4("sp3", 4'b1000, 3);
    grant_cycle4("sp_a", 4'b0110, RR ? 1 : 2);
    grant_cycle4("sp_b", 4'b0110, 2);
    x4 = 4'b0000;

    // Width sweep N=8
    for (int i = 0; i < 8; i++) begin
      x8 = 8'b0000_0001 << i;
      tick();
      check("n8_y", 32'(y8), 32'(i));
      check("n8_gnt", 32'(gnt8), 32'(x8));
      check("n8_v", 32'(v8), 32'(1));
      done8 = 1'b1;
      tick();
      check("n8_rel_v", 32'(v8), 32'(0));
      done8 = 1'b0;
    end
    x8 = '0;

    // Width sweep N=2
    for (int i = 0; i < 2; i++) begin
      x2 = 2'b01 << i;
      tick();
      check("n2_y", 32'(y2), 32'(i));
      check("n2_gnt", 32'(gnt2), 32'(x2));
      check("n2_v", 32'(v2), 32'(1));
      done2 = 1'b1;
      tick();
      check("n2_rel_v", 32'(v2), 32'(0));
      done2 = 1'b0;
    end
    x2 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
